// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and widths for the decode/execute/memory stages.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Control word carried from ID into EX and onward into the ex_mem stage.
  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_AW-1:0]  ws;
    logic               valid;
  } id_ex_ctrl_t;

  // True when a destination register ws matches a source the instruction actually reads.
  function automatic logic src_hit(input logic use1, input logic [REG_AW-1:0] rs1,
                                   input logic use2, input logic [REG_AW-1:0] rs2,
                                   input logic [REG_AW-1:0] ws);
    return (use1 && (rs1 == ws)) || (use2 && (rs2 == ws));
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, execute-side and bypass buses of the ID/EX pipeline register.
interface id_ex_stage_if;
  import cpu_pipe_pkg::*;

  logic                ID_valid;
  logic [REG_AW-1:0]   ID_rs1, ID_rs2, ID_ws;
  logic                ID_use_rs1, ID_use_rs2;
  logic [DATA_W-1:0]   ID_rd1, ID_rd2, ID_imm;
  logic                ID_regwrite, ID_memread, ID_memwrite;
  logic [ALUOP_W-1:0]  ID_alu_op;
  logic                EX_hold, EX_flush;
  logic                MEM_regwrite;
  logic [REG_AW-1:0]   MEM_ws;
  logic [DATA_W-1:0]   MEM_result;
  logic                WB_regwrite;
  logic [REG_AW-1:0]   WB_ws;
  logic [DATA_W-1:0]   WB_wd;

  logic                ID_stall;
  logic                EX_valid, EX_regwrite, EX_memread, EX_memwrite;
  logic [REG_AW-1:0]   EX_ws;
  logic [ALUOP_W-1:0]  EX_alu_op;
  logic [DATA_W-1:0]   EX_op1, EX_op2, EX_imm;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_ws, ID_use_rs1, ID_use_rs2, ID_rd1, ID_rd2, ID_imm,
           ID_regwrite, ID_memread, ID_memwrite, ID_alu_op, EX_hold, EX_flush,
           MEM_regwrite, MEM_ws, MEM_result, WB_regwrite, WB_ws, WB_wd,
    input  ID_stall, EX_valid, EX_regwrite, EX_memread, EX_memwrite, EX_ws, EX_alu_op,
           EX_op1, EX_op2, EX_imm, bubble_cnt
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_ws, ID_use_rs1, ID_use_rs2, ID_rd1, ID_rd2, ID_imm,
           ID_regwrite, ID_memread, ID_memwrite, ID_alu_op, EX_hold, EX_flush,
           MEM_regwrite, MEM_ws, MEM_result, WB_regwrite, WB_ws, WB_wd,
    output ID_stall, EX_valid, EX_regwrite, EX_memread, EX_memwrite, EX_ws, EX_alu_op,
           EX_op1, EX_op2, EX_imm, bubble_cnt
  );
endinterface

// File: rtl/id_ex_hazard.sv
// Combinational operand forwarding and hazard detection for the ID/EX stage.
// Build option ID_EX_FWD_EN: forward from MEM and stall only on load-use;
// otherwise only the WB bypass exists and any pending EX/MEM write to a used
// source stalls decode.
module id_ex_hazard
  import cpu_pipe_pkg::*;
(
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_ws,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_ws,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_ws,
  input  logic [DATA_W-1:0] wb_wd,
  output logic [DATA_W-1:0] op1_c,
  output logic [DATA_W-1:0] op2_c,
  output logic              hazard_c
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_valid && src_hit(use_rs1, rs1, use_rs2, rs2, ex_ws);
  assign mem_hit = mem_regwrite && src_hit(use_rs1, rs1, use_rs2, rs2, mem_ws);

  // Operand select: MEM result over WB write over register-file read.
  always_comb begin
    op1_c = rd1;
    op2_c = rd2;
    if (wb_regwrite && (wb_ws == rs1)) op1_c = wb_wd;
    if (wb_regwrite && (wb_ws == rs2)) op2_c = wb_wd;
`ifdef ID_EX_FWD_EN
    if (mem_regwrite && (mem_ws == rs1)) op1_c = mem_result;
    if (mem_regwrite && (mem_ws == rs2)) op2_c = mem_result;
`endif
  end

`ifdef ID_EX_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ex_regwrite ^ mem_hit;
`else
  logic unused_fwd;
  assign unused_fwd = ^mem_result;
`endif

  // Hazard: a load in EX always stalls; without MEM forwarding any pending write does.
  always_comb begin
    hazard_c = 1'b0;
    if (ex_hit && ex_memread) hazard_c = 1'b1;
`ifndef ID_EX_FWD_EN
    if (ex_hit && ex_regwrite) hazard_c = 1'b1;
    if (mem_hit) hazard_c = 1'b1;
`endif
    hazard_c = hazard_c && id_valid;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use stall and bubble counting.
// Build option ID_EX_FWD_EN enables forwarding from the MEM stage (see id_ex_hazard).
module id_ex_stage
  import cpu_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  id_ex_ctrl_t       ex_ctrl;
  id_ex_ctrl_t       id_ctrl_c;
  logic [DATA_W-1:0] ex_op1, ex_op2, ex_imm;
  logic [DATA_W-1:0] op1_c, op2_c;
  logic              hazard_c;
  logic [CNT_W-1:0]  cnt;

  id_ex_hazard u_hazard (
    .id_valid     (bus.ID_valid),
    .rs1          (bus.ID_rs1),
    .rs2          (bus.ID_rs2),
    .use_rs1      (bus.ID_use_rs1),
    .use_rs2      (bus.ID_use_rs2),
    .rd1          (bus.ID_rd1),
    .rd2          (bus.ID_rd2),
    .ex_valid     (ex_ctrl.valid),
    .ex_memread   (ex_ctrl.memread),
    .ex_regwrite  (ex_ctrl.regwrite),
    .ex_ws        (ex_ctrl.ws),
    .mem_regwrite (bus.MEM_regwrite),
    .mem_ws       (bus.MEM_ws),
    .mem_result   (bus.MEM_result),
    .wb_regwrite  (bus.WB_regwrite),
    .wb_ws        (bus.WB_ws),
    .wb_wd        (bus.WB_wd),
    .op1_c        (op1_c),
    .op2_c        (op2_c),
    .hazard_c     (hazard_c)
  );

  // Decoded control word; an invalid decode slot enters EX as an all-zero bubble.
  always_comb begin
    id_ctrl_c = '0;
    if (bus.ID_valid) begin
      id_ctrl_c.regwrite = bus.ID_regwrite;
      id_ctrl_c.memread  = bus.ID_memread;
      id_ctrl_c.memwrite = bus.ID_memwrite;
      id_ctrl_c.alu_op   = bus.ID_alu_op;
      id_ctrl_c.ws       = bus.ID_ws;
      id_ctrl_c.valid    = 1'b1;
    end
  end

  // Pipeline register: flush beats hold beats hazard bubble beats normal capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl <= '0;
      ex_op1  <= '0;
      ex_op2  <= '0;
      ex_imm  <= '0;
      cnt     <= '0;
    end else if (bus.EX_flush) begin
      ex_ctrl <= '0;
    end else if (!bus.EX_hold) begin
      if (hazard_c) begin
        ex_ctrl <= '0;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end else begin
        ex_ctrl <= id_ctrl_c;
        ex_op1  <= op1_c;
        ex_op2  <= op2_c;
        ex_imm  <= bus.ID_imm;
      end
    end
  end

  assign bus.ID_stall    = !reset && (hazard_c || bus.EX_hold);
  assign bus.EX_valid    = ex_ctrl.valid;
  assign bus.EX_regwrite = ex_ctrl.regwrite;
  assign bus.EX_memread  = ex_ctrl.memread;
  assign bus.EX_memwrite = ex_ctrl.memwrite;
  assign bus.EX_ws       = ex_ctrl.ws;
  assign bus.EX_alu_op   = ex_ctrl.alu_op;
  assign bus.EX_op1      = ex_op1;
  assign bus.EX_op2      = ex_op2;
  assign bus.EX_imm      = ex_imm;
  assign bus.bubble_cnt  = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural model of the EX register contents plus directed literals.
module tb_id_ex_stage;
  import cpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  id_ex_stage_if bus();

  id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of what execute must hold.
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [2:0]  m_ws;
  logic [3:0]  m_op;
  logic [31:0] m_op1, m_op2, m_imm;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic uses(input logic [2:0] w);
    return (bus.ID_use_rs1 && bus.ID_rs1 == w) || (bus.ID_use_rs2 && bus.ID_rs2 == w);
  endfunction

  function automatic logic model_hazard();
    logic h;
    h = m_valid && m_mr && uses(m_ws);
`ifndef ID_EX_FWD_EN
    if (m_valid && m_rw && uses(m_ws)) h = 1'b1;
    if (bus.MEM_regwrite && uses(bus.MEM_ws)) h = 1'b1;
`endif
    return bus.ID_valid && h;
  endfunction

  function automatic logic [31:0] pick(input logic [2:0] rs, input logic [31:0] rd);
`ifdef ID_EX_FWD_EN
    if (bus.MEM_regwrite && bus.MEM_ws == rs) return bus.MEM_result;
`endif
    if (bus.WB_regwrite && bus.WB_ws == rs) return bus.WB_wd;
    return rd;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ws = 0; m_op = 0;
    m_op1 = 0; m_op2 = 0; m_imm = 0; m_cnt = 0;
  endtask

  // Compare every observable output against the model.
  task automatic compare();
    chk("stall", 32'(bus.ID_stall), 32'(model_hazard() || bus.EX_hold));
    chk("ex_valid", 32'(bus.EX_valid), 32'(m_valid));
    chk("ex_regwrite", 32'(bus.EX_regwrite), 32'(m_rw));
    chk("ex_memread", 32'(bus.EX_memread), 32'(m_mr));
    chk("ex_memwrite", 32'(bus.EX_memwrite), 32'(m_mw));
    chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk("ex_ws", 32'(bus.EX_ws), 32'(m_ws));
      chk("ex_alu_op", 32'(bus.EX_alu_op), 32'(m_op));
      chk("ex_op1", bus.EX_op1, m_op1);
      chk("ex_op2", bus.EX_op2, m_op2);
      chk("ex_imm", bus.EX_imm, m_imm);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (bus.EX_flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else if (!bus.EX_hold) begin
      if (model_hazard()) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_valid = bus.ID_valid;
        m_rw    = bus.ID_valid && bus.ID_regwrite;
        m_mr    = bus.ID_valid && bus.ID_memread;
        m_mw    = bus.ID_valid && bus.ID_memwrite;
        m_ws    = bus.ID_ws;
        m_op    = bus.ID_alu_op;
        m_op1   = pick(bus.ID_rs1, bus.ID_rd1);
        m_op2   = pick(bus.ID_rs2, bus.ID_rd2);
        m_imm   = bus.ID_imm;
      end
    end
  endtask

  // Inputs are applied 1 after a rising edge; outputs compared on the falling edge.
  task automatic tick();
    #4;
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ID_valid = 0; bus.ID_rs1 = 0; bus.ID_rs2 = 0; bus.ID_ws = 0;
    bus.ID_use_rs1 = 0; bus.ID_use_rs2 = 0; bus.ID_rd1 = 0; bus.ID_rd2 = 0; bus.ID_imm = 0;
    bus.ID_regwrite = 0; bus.ID_memread = 0; bus.ID_memwrite = 0; bus.ID_alu_op = 0;
    bus.EX_hold = 0; bus.EX_flush = 0;
    bus.MEM_regwrite = 0; bus.MEM_ws = 0; bus.MEM_result = 0;
    bus.WB_regwrite = 0; bus.WB_ws = 0; bus.WB_wd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic set_instr(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                           input logic u2, input logic [2:0] ws, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic rw, input logic mr);
    bus.ID_valid = 1; bus.ID_rs1 = rs1; bus.ID_use_rs1 = u1; bus.ID_rs2 = rs2;
    bus.ID_use_rs2 = u2; bus.ID_ws = ws; bus.ID_rd1 = rd1; bus.ID_rd2 = rd2;
    bus.ID_imm = 32'hFFFF_FFF0; bus.ID_regwrite = rw; bus.ID_memread = mr;
    bus.ID_memwrite = 0; bus.ID_alu_op = ALU_ADD;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_clear();
    #2;
    @(posedge clk);
    #1;
    reset = 0;
    // Reset state.
    chk("rst_valid", 32'(bus.EX_valid), 32'd0);
    chk("rst_op1", bus.EX_op1, 32'd0);
    chk("rst_cnt", 32'(bus.bubble_cnt), 32'd0);
    chk("rst_stall", 32'(bus.ID_stall), 32'd0);

    // Back-to-back independent instructions.
    set_instr(3'd1, 1, 3'd2, 1, 3'd3, 32'd5, 32'd7, 1, 0);
    tick();
    chk("indep_op1", bus.EX_op1, 32'd5);
    chk("indep_op2", bus.EX_op2, 32'd7);
    chk("indep_valid", 32'(bus.EX_valid), 32'd1);
    set_instr(3'd5, 1, 3'd6, 1, 3'd7, 32'd1, 32'd2, 1, 0);
    #1;
    chk("indep_stall", 32'(bus.ID_stall), 32'd0);
    tick();
    chk("indep_cnt", 32'(bus.bubble_cnt), 32'd0);

    // WB bypass of a register being written this same edge.
    set_instr(3'd0, 1, 3'd2, 1, 3'd1, 32'd3, 32'h99, 1, 0);
    bus.WB_regwrite = 1; bus.WB_ws = 3'd2; bus.WB_wd = 32'h20;
    tick();
    chk("wb_op2", bus.EX_op2, 32'h20);
    chk("wb_op1", bus.EX_op1, 32'd3);

`ifdef ID_EX_FWD_EN
    // MEM forwarding, and MEM priority over WB.
    do_reset();
    set_instr(3'd3, 1, 3'd0, 0, 3'd1, 32'h11, 32'h0, 1, 0);
    bus.MEM_regwrite = 1; bus.MEM_ws = 3'd3; bus.MEM_result = 32'hAA;
    tick();
    chk("mem_op1", bus.EX_op1, 32'hAA);
    set_instr(3'd0, 0, 3'd2, 1, 3'd1, 32'h0, 32'h99, 1, 0);
    bus.MEM_ws = 3'd2; bus.MEM_result = 32'h10;
    bus.WB_regwrite = 1; bus.WB_ws = 3'd2; bus.WB_wd = 32'h20;
    tick();
    chk("mem_wb_op2", bus.EX_op2, 32'h10);
`endif

    // Load-use: one bubble, then the load value arrives from MEM.
    do_reset();
    set_instr(3'd0, 0, 3'd0, 0, 3'd4, 32'h0, 32'h0, 1, 1);
    tick();
    set_instr(3'd4, 1, 3'd0, 0, 3'd5, 32'h11, 32'h0, 1, 0);
    #1;
    chk("lu_stall", 32'(bus.ID_stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(bus.EX_valid), 32'd0);
    chk("lu_cnt", 32'(bus.bubble_cnt), 32'd1);
    bus.MEM_regwrite = 1; bus.MEM_ws = 3'd4; bus.MEM_result = 32'h1234;
`ifdef ID_EX_FWD_EN
    #1;
    chk("lu_release", 32'(bus.ID_stall), 32'd0);
    tick();
    chk("lu_op1", bus.EX_op1, 32'h1234);
    chk("lu_cnt2", 32'(bus.bubble_cnt), 32'd1);
`else
    #1;
    chk("lu_mem_stall", 32'(bus.ID_stall), 32'd1);
    tick();
    bus.MEM_regwrite = 0; bus.WB_regwrite = 1; bus.WB_ws = 3'd4; bus.WB_wd = 32'h1234;
    #1;
    chk("lu_release", 32'(bus.ID_stall), 32'd0);
    tick();
    chk("lu_op1", bus.EX_op1, 32'h1234);
    chk("lu_cnt2", 32'(bus.bubble_cnt), 32'd2);
`endif
    chk("lu_valid", 32'(bus.EX_valid), 32'd1);

    // Hold keeps EX, reset mid-hold clears without an edge, flush beats hold.
    do_reset();
    set_instr(3'd0, 0, 3'd0, 0, 3'd1, 32'h0, 32'h0, 1, 0);
    tick();
    bus.EX_hold = 1;
    bus.ID_ws = 3'd2;
    tick();
    chk("hold_valid", 32'(bus.EX_valid), 32'd1);
    chk("hold_ws", 32'(bus.EX_ws), 32'd1);
    #2;
    reset = 1;
    #1;
    chk("arst_valid", 32'(bus.EX_valid), 32'd0);
    chk("arst_regwrite", 32'(bus.EX_regwrite), 32'd0);
    chk("arst_stall", 32'(bus.ID_stall), 32'd0);
    chk("arst_op1", bus.EX_op1, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    bus.EX_hold = 0;
    tick();
    bus.EX_flush = 1; bus.EX_hold = 1;
    tick();
    chk("flush_valid", 32'(bus.EX_valid), 32'd0);
    chk("flush_regwrite", 32'(bus.EX_regwrite), 32'd0);
    chk("flush_cnt", 32'(bus.bubble_cnt), 32'd0);

`ifndef ID_EX_FWD_EN
    // ALU RAW without MEM forwarding: two bubbles, operand via WB.
    do_reset();
    set_instr(3'd1, 1, 3'd2, 1, 3'd6, 32'h1, 32'h2, 1, 0);
    tick();
    set_instr(3'd6, 1, 3'd0, 0, 3'd7, 32'hDEAD, 32'h0, 1, 0);
    tick();
    bus.MEM_regwrite = 1; bus.MEM_ws = 3'd6; bus.MEM_result = 32'h66;
    #1;
    chk("raw_stall2", 32'(bus.ID_stall), 32'd1);
    tick();
    bus.MEM_regwrite = 0; bus.WB_regwrite = 1; bus.WB_ws = 3'd6; bus.WB_wd = 32'h66;
    tick();
    chk("raw_op1", bus.EX_op1, 32'h66);
    chk("raw_cnt", 32'(bus.bubble_cnt), 32'd2);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.ID_valid    = ($urandom_range(0, 99) < 85);
      bus.ID_rs1      = 3'($urandom_range(0, 7));
      bus.ID_rs2      = 3'($urandom_range(0, 7));
      bus.ID_ws       = 3'($urandom_range(0, 7));
      bus.ID_use_rs1  = 1'($urandom_range(0, 1));
      bus.ID_use_rs2  = 1'($urandom_range(0, 1));
      bus.ID_rd1      = $urandom;
      bus.ID_rd2      = $urandom;
      bus.ID_imm      = $urandom;
      bus.ID_regwrite = 1'($urandom_range(0, 1));
      bus.ID_memread  = ($urandom_range(0, 99) < 25);
      bus.ID_memwrite = ($urandom_range(0, 99) < 15);
      bus.ID_alu_op   = 4'($urandom_range(0, 9));
      bus.EX_hold     = ($urandom_range(0, 99) < 10);
      bus.EX_flush    = ($urandom_range(0, 99) < 5);
      bus.MEM_regwrite = 1'($urandom_range(0, 1));
      bus.MEM_ws      = 3'($urandom_range(0, 7));
      bus.MEM_result  = $urandom;
      bus.WB_regwrite = 1'($urandom_range(0, 1));
      bus.WB_ws       = 3'($urandom_range(0, 7));
      bus.WB_wd       = $urandom;
      tick();
    end

`ifndef ID_EX_FWD_EN
    // Continuous MEM hazard drives the counter into saturation.
    do_reset();
    set_instr(3'd1, 1, 3'd0, 0, 3'd2, 32'h0, 32'h0, 1, 0);
    bus.MEM_regwrite = 1; bus.MEM_ws = 3'd1;
    for (int i = 0; i < 65540; i++) tick();
    chk("sat_cnt", 32'(bus.bubble_cnt), 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (register-file read) and execute.
- Captures decoded control, the two register-file read values and the immediate.
- Applies operand forwarding from MEM and WB, and detects load-use hazards.
- Drives ID_stall upstream and inserts bubbles/flushes into execute.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 3, register address width (8 registers)
ALUOP_W, 4, ALU opcode width
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
ID_valid  in  1  decode holds a real instruction
ID_rs1, ID_rs2, ID_ws  in  REG_AW  source/dest register addresses
ID_use_rs1, ID_use_rs2  in  1  instruction actually reads rs1/rs2
ID_rd1, ID_rd2  in  DATA_W  register-file read data
ID_imm  in  DATA_W  sign-extended immediate
ID_regwrite, ID_memread, ID_memwrite  in  1  decoded control
ID_alu_op  in  ALUOP_W  ALU opcode
EX_hold  in  1  execute busy; freeze this stage
EX_flush  in  1  taken branch/jump resolved in execute; kill the instruction entering
MEM_regwrite  in  1, MEM_ws  in  REG_AW, MEM_result  in  DATA_W  MEM-stage pending write
WB_regwrite  in  1, WB_ws  in  REG_AW, WB_wd  in  DATA_W  WB write (same bus as the register-file write port)
ID_stall  out  1  freeze PC and IF/ID this cycle
EX_valid, EX_regwrite, EX_memread, EX_memwrite  out  1  registered control
EX_ws  out  REG_AW; EX_alu_op  out  ALUOP_W
EX_op1, EX_op2, EX_imm  out  DATA_W  registered operands
bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, immediate): all EX_* outputs are 0, bubble_cnt is 0, and ID_stall is 0.
- Operand select per source, in priority order, with no address-0 special case:
  - MEM_regwrite and MEM_ws==rs: MEM_result.
  - Else WB_regwrite and WB_ws==rs: WB_wd.
  - Else ID_rdN.
- WB bypass is always present, because the register file writes in the same edge as it is read.
- Load-use hazard (combinational): ID_valid && EX_valid && EX_memread && EX_ws matches a used source.
- ID_stall = hazard || EX_hold.
- Per-edge update priority: reset > EX_flush > EX_hold > hazard > normal.
  - EX_flush: EX_valid and all EX control bits cleared (bubble); the ID instruction is dropped because upstream flushes too. This applies even when EX_hold is set.
  - EX_hold (no flush): all EX_* registers keep their values.
  - hazard: bubble inserted (EX_valid=0, control 0, data don't-care held); bubble_cnt += 1, saturating at all-ones. The same ID instruction re-evaluates next cycle and forwards from MEM.
  - normal: register the ID fields with forwarded operands; EX_valid = ID_valid; control bits are gated by ID_valid.
- Latency: one cycle from ID to EX.
- A load-use stall is exactly one bubble, since the load reaches MEM the next cycle.
- Flush does not increment bubble_cnt.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: MEM forwarding as above; hazard = load-use only.
- Undefined: no MEM forwarding; WB bypass is retained.
  - Hazard also asserts when an EX instruction with regwrite, or a MEM stage with MEM_regwrite, targets a used source.
  - This gives up to 2 bubbles per RAW dependency; each bubble is counted.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - DATA_W, REG_AW, ALUOP_W constants.
  - ALU opcode enum.
  - A packed id_ex_ctrl_t struct (regwrite, memread, memwrite, alu_op, ws, valid), reused by the ex_mem stage.
- One sub-module, id_ex_hazard: purely combinational hazard detection plus the forwarding-select logic. It is instanced once; the pipeline registers stay in the top.

Test Plan:
- Back-to-back independent: ID r1=5, r2=7, alu_op=ADD, then a second instruction -> EX_op1=5, EX_op2=7 one cycle later; no stall; bubble_cnt=0.
- MEM forward: MEM_regwrite=1, MEM_ws=3, MEM_result=0xAA, ID_rs1=3, ID_rd1=0x11 -> EX_op1=0xAA.
- MEM and WB both target rs2=2 (0x10 vs 0x20) -> EX_op2=0x10.
- Load-use: EX holds memread, ws=4; ID uses rs1=4 -> ID_stall=1 for exactly one cycle, EX_valid=0 for one cycle, bubble_cnt=1. The next EX carries the forwarded MEM_result.
- EX_flush and EX_hold asserted together with a valid ID -> next EX_valid=0, regwrite=0, bubble_cnt unchanged. Assert reset mid-hold -> all outputs 0 immediately, with no clock edge needed.
- Without ID_EX_FWD_EN: ALU instruction writes r6, dependent instruction uses r6 -> two bubbles, bubble_cnt=2, and the operand is taken via the WB bypass. Drive 65540 hazards -> bubble_cnt saturates at 0xFFFF.
